// File: rtl/haar_pair_butterfly_if.sv
// haar_pair_butterfly_if: serial sample input and parallel frame output bundle for haar_pair_butterfly.
// With HAAR_SAT_STATUS_EN defined the bundle also carries sat_flag.
interface haar_pair_butterfly_if #(parameter int DW = 12);
  logic          clear;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] o [8];
  logic [2:0]    fill_cnt;
`ifdef HAAR_SAT_STATUS_EN
  logic          sat_flag;
`endif
  modport master (
    output clear, in_data, in_valid, out_ready,
    input  in_ready, out_valid, o, fill_cnt
`ifdef HAAR_SAT_STATUS_EN
    , sat_flag
`endif
  );
  modport slave (
    input  clear, in_data, in_valid, out_ready,
    output in_ready, out_valid, o, fill_cnt
`ifdef HAAR_SAT_STATUS_EN
    , sat_flag
`endif
  );
endinterface

// File: rtl/haar_pair_butterfly.sv
// haar_pair_butterfly: buffers 8 serial sign-magnitude samples, emits pair sums/differences with saturation.
// Optional HAAR_SAT_STATUS_EN adds a registered sat_flag set when any result of the frame saturated.
module haar_pair_butterfly #(
  parameter int DW = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  haar_pair_butterfly_if.slave bus
);
  localparam int SW = DW + 2;
  localparam logic [SW-1:0] MAX = SW'((1 << (DW - 1)) - 1);
  typedef enum logic [1:0] {FILL, CALC, HOLD} state_t;
  state_t               r_state;
  logic [DW-1:0]        r_x [8];
  logic [DW-1:0]        r_o [8];
  logic [2:0]           r_cnt;
  logic                 r_valid;
  logic signed [SW-1:0] w_sum [8];
  logic [DW-1:0]        w_res [8];
  function automatic logic signed [SW-1:0] to_s(input logic [DW-1:0] v);
    logic signed [SW-1:0] m;
    m = $signed({3'b000, v[DW-2:0]});
    return v[DW-1] ? -m : m;
  endfunction
  function automatic logic [SW-1:0] mag(input logic signed [SW-1:0] s);
    return s[SW-1] ? -s : s;
  endfunction
  // a zero sum never has its sign bit set, so -0 collapses to +0 here
  function automatic logic [DW-1:0] to_sm(input logic signed [SW-1:0] s);
    logic [SW-1:0] a;
    a = mag(s);
    return {s[SW-1], a > MAX ? MAX[DW-2:0] : a[DW-2:0]};
  endfunction
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_sum[i]     = to_s(r_x[2*i]) + to_s(r_x[2*i+1]);
      w_sum[i+4]   = to_s(r_x[2*i]) - to_s(r_x[2*i+1]);
    end
    for (int i = 0; i < 8; i++) w_res[i] = to_sm(w_sum[i]);
  end
`ifdef HAAR_SAT_STATUS_EN
  logic r_sat;
  logic w_sat;
  always_comb begin
    w_sat = 1'b0;
    for (int i = 0; i < 8; i++) w_sat = w_sat | (mag(w_sum[i]) > MAX);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_sat <= 1'b0;
    else if (r_state == CALC) r_sat <= w_sat;
    else if (r_state == HOLD && bus.out_ready) r_sat <= 1'b0;
  assign bus.sat_flag = r_sat;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_x[i] <= '0;
        r_o[i] <= '0;
      end
    end else begin
      case (r_state)
        FILL:
          if (bus.clear) r_cnt <= '0;
          else if (bus.in_valid) begin
            r_x[r_cnt] <= bus.in_data;
            r_cnt      <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= CALC;
          end
        CALC: begin
          for (int i = 0; i < 8; i++) r_o[i] <= w_res[i];
          r_valid <= 1'b1;
          r_state <= HOLD;
        end
        default:
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= FILL;
          end
      endcase
    end
  end
  always_comb begin
    for (int i = 0; i < 8; i++) bus.o[i] = r_o[i];
  end
  assign bus.in_ready  = (r_state == FILL) && !i_rst;
  assign bus.out_valid = r_valid;
  assign bus.fill_cnt  = r_cnt;
endmodule

// File: tb/tb_haar_pair_butterfly.sv
// tb_haar_pair_butterfly: directed and randomized frames checked against an integer-arithmetic model.
// Define HAAR_SAT_STATUS_EN to also check sat_flag.
module tb_haar_pair_butterfly;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [11:0] m_buf [8];
  int   m_cnt = 0;
  haar_pair_butterfly_if #(.DW(12)) bus ();
  haar_pair_butterfly #(.DW(12)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int sm2i(input logic [11:0] v);
    int m;
    m = int'(v & 12'h7FF);
    return v[11] ? -m : m;
  endfunction
  function automatic logic [11:0] i2sm(input int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    if (m == 0) return 12'h000;
    return (v < 0) ? 12'h800 | 12'(m) : 12'(m);
  endfunction
  function automatic logic [11:0] model(input int k);
    int a, b;
    a = sm2i(m_buf[2*(k%4)]);
    b = sm2i(m_buf[2*(k%4)+1]);
    return i2sm(k < 4 ? a + b : a - b);
  endfunction
  function automatic int model_sat();
    int a, b, s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      a = sm2i(m_buf[2*k]);
      b = sm2i(m_buf[2*k+1]);
      if (a + b > 2047 || a + b < -2047 || a - b > 2047 || a - b < -2047) s = 1;
    end
    return s;
  endfunction
  task automatic push(input logic [11:0] s);
    bus.in_data  = s;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    m_buf[m_cnt] = s;
    m_cnt = (m_cnt + 1) % 8;
    if (m_cnt != 0) check("fill_cnt", int'(bus.fill_cnt), m_cnt);
  endtask
  task automatic check_outs(input string tag);
    for (int k = 0; k < 8; k++) check($sformatf("%s_o%0d", tag, k), int'(bus.o[k]), int'(model(k)));
`ifdef HAAR_SAT_STATUS_EN
    check({tag, "_sat"}, int'(bus.sat_flag), model_sat());
`endif
  endtask
  task automatic do_frame(input logic [11:0] s [8], input int hold);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      push(s[i]);
    end
    check("calc_valid", int'(bus.out_valid), 0);
    check("calc_in_ready", int'(bus.in_ready), 0);
    check("calc_fill_cnt", int'(bus.fill_cnt), 0);
    @(posedge clk); #1;
    check("out_valid", int'(bus.out_valid), 1);
    check_outs("res");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int h = 0; h < hold; h++) begin
      bus.in_data = 12'($urandom);
      @(posedge clk); #1;
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
      check("hold_fill_cnt", int'(bus.fill_cnt), 0);
      check_outs("hold");
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("done_valid", int'(bus.out_valid), 0);
    check("done_in_ready", int'(bus.in_ready), 1);
    check("done_fill_cnt", int'(bus.fill_cnt), 0);
`ifdef HAAR_SAT_STATUS_EN
    check("done_sat", int'(bus.sat_flag), 0);
`endif
  endtask
  initial begin
    logic [11:0] f [8];
    bus.clear = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #2;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_fill_cnt", int'(bus.fill_cnt), 0);
    check("rst_o0", int'(bus.o[0]), 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", int'(bus.in_ready), 1);
    f = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60, 12'd70, 12'd80};
    do_frame(f, 0);
    check("ramp_o0", int'(bus.o[0]), 12'h01E);
    check("ramp_o3", int'(bus.o[3]), 12'h096);
    check("ramp_o7", int'(bus.o[7]), 12'h80A);
    f = '{12'h7D0, 12'h7D0, 12'h7D0, 12'hFD0, 12'h7FF, 12'hFFF, 12'h000, 12'h800};
    do_frame(f, 2);
    check("sat_o0", int'(bus.o[0]), 12'h7FF);
    check("sat_o5", int'(bus.o[5]), 12'h7FF);
    f = '{12'h800, 12'h000, 12'd5, 12'd5, 12'h800, 12'h800, 12'h805, 12'h003};
    do_frame(f, 5);
    check("zero_o0", int'(bus.o[0]), 12'h000);
    check("zero_o1", int'(bus.o[1]), 12'h00A);
    check("zero_o6", int'(bus.o[6]), 12'h000);
    for (int i = 0; i < 4; i++) push(12'($urandom));
    #3 rst = 1'b1;
    #1;
    check("arst_valid", int'(bus.out_valid), 0);
    check("arst_fill_cnt", int'(bus.fill_cnt), 0);
    check("arst_o2", int'(bus.o[2]), 0);
    m_cnt = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) f[i] = 12'($urandom);
    do_frame(f, 1);
    for (int i = 0; i < 3; i++) push(12'($urandom));
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 12'h123;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    m_cnt = 0;
    check("clear_fill_cnt", int'(bus.fill_cnt), 0);
    for (int i = 0; i < 8; i++) f[i] = 12'($urandom);
    do_frame(f, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("idle_valid", int'(bus.out_valid), 0);
    end
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 8; i++)
        f[i] = ($urandom_range(0, 3) == 0) ? (12'($urandom) | 12'h7C0) : 12'($urandom);
      do_frame(f, $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/haar_pair_butterfly.md
Name: haar_pair_butterfly

Overview:
- Upstream neighbour of the 8-point scaling/shift stage.
- Collects eight serial 12-bit sign-magnitude samples into a frame buffer.
- Computes the Haar butterfly on adjacent pairs and presents eight parallel words with a valid/ready handshake.
- O0..O3 carry pair sums (approximation, scaled by 0.7071 downstream); O4..O7 carry pair differences (detail, shifted downstream).

Parameters:
- DW, 12, data word width in sign-magnitude: bit DW-1 is the sign, bits DW-2:0 are the magnitude.
- Frame size is fixed at 8 and is not a parameter.

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- CLEAR  input  1  synchronous abort of a partial frame
- IN_DATA  input  DW  serial sample, sign-magnitude
- IN_VALID  input  1  IN_DATA valid
- IN_READY  output  1  block can accept a sample
- OUT_READY  input  1  downstream accepts the frame
- OUT_VALID  output  1  O0..O7 valid
- O0..O7  output  DW each  butterfly results, sign-magnitude
- FILL_CNT  output  3  samples held in the current partial frame

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: O0..O7=0, OUT_VALID=0, FILL_CNT=0, state=FILL, buffer x0..x7 cleared. IN_READY=1 once reset deasserts.
- FSM states: FILL, CALC, HOLD.
- FILL:
  - IN_READY=1.
  - A sample is accepted on an edge where IN_VALID=1, and is written to x[FILL_CNT]; FILL_CNT then increments.
  - Accepting the 8th sample (FILL_CNT=7) wraps FILL_CNT to 0 and moves to CALC.
- CALC (exactly one cycle):
  - IN_READY=0.
  - On the edge: O0..O7 registered, OUT_VALID<=1, go to HOLD.
- HOLD:
  - IN_READY=0. O0..O7 are held stable.
  - On an edge with OUT_READY=1: OUT_VALID<=0, go to FILL.
  - No new sample is accepted on that edge.
- Latency: 8th sample accepted at edge k; OUT_VALID high after edge k+1.
- Arithmetic, for i=0..3, with a=x[2i] and b=x[2i+1]:
  - O[i] = a+b and O[i+4] = a-b, both computed with signed arithmetic on sign-magnitude operands.
  - Result magnitude saturates at 2^(DW-1)-1 (2047); the sign is kept.
  - Zero results are always +0 (sign bit cleared), including -0 inputs combined with ±0.
- CLEAR:
  - In FILL: FILL_CNT<=0 and any sample offered on the same edge is dropped (CLEAR wins).
  - In CALC or HOLD: ignored.
- RESET mid-frame or mid-HOLD: immediate return to reset values; the partial or held frame is lost.
- IN_VALID while IN_READY=0: ignored, no side effects.
- OUT_READY while OUT_VALID=0: ignored.

Optional Feature:
- Macro: HAAR_SAT_STATUS_EN.
- Defined:
  - Adds output SAT_FLAG (1 bit), registered alongside O0..O7.
  - SAT_FLAG=1 if any of the 8 results saturated in the current frame.
  - Cleared to 0 on reset and when the HOLD handshake completes.
- Not defined: port absent; saturation behaviour is unchanged.

Test Plan:
- Ramp frame:
  - Stimulus: samples +10,+20,+30,+40,+50,+60,+70,+80, OUT_READY=1.
  - Response: O0..O3 = 12'h01E, 12'h046, 12'h06E, 12'h096; O4..O7 = 12'h80A each (-10); OUT_VALID high for 1 cycle, one cycle after the 8th accept.
- Saturation:
  - Stimulus: x0=+2000 (12'h7D0), x1=+2000; x2=+2000, x3=-2000 (12'hFD0).
  - Response: O0=12'h7FF, O1=12'h000, O4=12'h000, O5=12'h7FF; SAT_FLAG=1 when the macro is defined.
- Zero sign:
  - Stimulus: x0=12'h800 (-0), x1=12'h000; x2=+5, x3=+5.
  - Response: O0=12'h000, O4=12'h000, O1=12'h00A, O5=12'h000; no 12'h800 appears on any output.
- Backpressure:
  - Stimulus: OUT_READY=0 for 5 cycles after OUT_VALID, IN_VALID=1 throughout.
  - Response: O0..O7 stable, IN_READY=0, FILL_CNT=0, no sample captured. OUT_READY=1 → OUT_VALID falls on the next edge, IN_READY=1 after it.
- Reset mid-frame:
  - Stimulus: assert RESET asynchronously after 4 accepted samples.
  - Response: outputs, OUT_VALID and FILL_CNT are 0 immediately, without a clock edge. The next 8 samples form a fresh frame with correct results.
- CLEAR collision:
  - Stimulus: 3 samples accepted, then CLEAR=1 and IN_VALID=1 on the same edge.
  - Response: FILL_CNT=0 and the sample is dropped. The next 8 samples produce exactly one frame.
